// File: rtl/rr_mux_arbiter.sv
// Round-robin 8:1 arbitrating mux with a registered single-word output stage.
// Define MUXARB_STATS_EN to add the 16-bit transfer counter output xfer_cnt.
module rr_mux_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   req,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] a2,
  input  logic [N-1:0] a3,
  input  logic [N-1:0] a4,
  input  logic [N-1:0] a5,
  input  logic [N-1:0] a6,
  input  logic [N-1:0] a7,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef MUXARB_STATS_EN
  ,
  output logic [15:0]  xfer_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state, state_nxt;
  logic [2:0]   ptr;
  logic [2:0]   win;
  logic [2:0]   idx;
  logic         found;
  logic         accept;
  logic         capture;
  logic [N-1:0] lanes [8];

  assign lanes[0] = a0;
  assign lanes[1] = a1;
  assign lanes[2] = a2;
  assign lanes[3] = a3;
  assign lanes[4] = a4;
  assign lanes[5] = a5;
  assign lanes[6] = a6;
  assign lanes[7] = a7;

  assign out_valid = (state == HOLD);
  assign accept    = (state == IDLE) || out_ready;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    capture   = rst_n && accept && found;
    gnt       = '0;
    state_nxt = state;
    if (capture) begin
      gnt       = 8'b1 << win;
      state_nxt = HOLD;
    end else if (state == HOLD && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      sel      <= '0;
      out_data <= '0;
    end else if (capture) begin
      ptr      <= win + 3'd1;
      sel      <= win;
      out_data <= lanes[win];
    end
  end

`ifdef MUXARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] lanes [8];
  logic [7:0] gnt;
  logic [2:0] sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef MUXARB_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model of the output word and the round-robin pointer
  bit       mValid;
  int       mData;
  int       mSel;
  int       mPtr;
  int       mCnt;
  logic [7:0] lastGnt;

  rr_mux_arbiter #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(lanes[0]), .a1(lanes[1]), .a2(lanes[2]), .a3(lanes[3]),
    .a4(lanes[4]), .a5(lanes[5]), .a6(lanes[6]), .a7(lanes[7]),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUXARB_STATS_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int firstFrom(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check grant, advance model, check registers
  task automatic applyStimulus(input logic rstn, input logic [7:0] r, input logic rdy);
    int w;
    int expGnt;
    bit cap;
    @(negedge clk);
    rst_n = rstn; req = r; out_ready = rdy;
    #1;
    w = firstFrom(mPtr, r);
    cap = rstn && (!mValid || rdy) && (w >= 0);
    expGnt = cap ? (1 << w) : 0;
    lastGnt = gnt;
    checkOutput("gnt", {24'd0, gnt}, expGnt);
    @(posedge clk);
    if (!rstn) begin
      mValid = 0; mData = 0; mSel = 0; mPtr = 0; mCnt = 0;
    end else begin
      if (mValid && rdy) mCnt = (mCnt + 1) % 65536;
      if (cap) begin
        mValid = 1; mData = lanes[w]; mSel = w; mPtr = (w + 1) % 8;
      end else if (mValid && rdy) begin
        mValid = 0;
      end
    end
    #1;
    checkOutput("out_valid", {31'd0, out_valid}, mValid);
    checkOutput("out_data", {24'd0, out_data}, mData);
    checkOutput("sel", {29'd0, sel}, mSel);
`ifdef MUXARB_STATS_EN
    checkOutput("xfer_cnt", {16'd0, xfer_cnt}, mCnt);
`endif
  endtask

  initial begin
    mValid = 0; mData = 0; mSel = 0; mPtr = 0; mCnt = 0;
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) lanes[i] = 8'hB0 + 8'(i);
    lanes[0] = 8'hA5;

    applyStimulus(0, 8'hFF, 1);
    applyStimulus(0, 8'hFF, 1);
    checkOutput("reset_gnt", {24'd0, lastGnt}, 0);
    checkOutput("reset_valid", {31'd0, out_valid}, 0);
    checkOutput("reset_data", {24'd0, out_data}, 0);

    // Single requester, one-cycle latency
    applyStimulus(1, 8'h01, 1);
    checkOutput("first_gnt", {24'd0, lastGnt}, 8'h01);
    checkOutput("first_valid", {31'd0, out_valid}, 1);
    checkOutput("first_data", {24'd0, out_data}, 8'hA5);
    checkOutput("first_sel", {29'd0, sel}, 0);
    applyStimulus(1, 8'h00, 1);
    checkOutput("drain_valid", {31'd0, out_valid}, 0);

    // Full request vector rotates through every lane
    applyStimulus(0, 8'h00, 1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 8'hFF, 1);
      checkOutput("rotate_sel", {29'd0, sel}, i % 8);
      checkOutput("rotate_valid", {31'd0, out_valid}, 1);
    end

    // Backpressure freezes the word and blocks grants
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'hFF, 0);
      checkOutput("stall_gnt", {24'd0, lastGnt}, 0);
      checkOutput("stall_sel", {29'd0, sel}, 0);
    end
    applyStimulus(1, 8'hFF, 1);
    checkOutput("resume_sel", {29'd0, sel}, 1);

    // Pointer at 6 with requesters 0 and 6: 6 then wrap to 0
    applyStimulus(0, 8'h00, 1);
    applyStimulus(1, 8'h20, 1);
    applyStimulus(1, 8'h41, 1);
    checkOutput("wrap_sel6", {29'd0, sel}, 6);
    applyStimulus(1, 8'h41, 1);
    checkOutput("wrap_sel0", {29'd0, sel}, 0);

    // Reset in HOLD discards the word
    applyStimulus(1, 8'hFF, 0);
    applyStimulus(0, 8'hFF, 0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_sel", {29'd0, sel}, 0);
    checkOutput("midrst_data", {24'd0, out_data}, 0);
    applyStimulus(1, 8'b0000_1100, 1);
    checkOutput("postrst_sel", {29'd0, sel}, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      for (int j = 0; j < 8; j++) lanes[j] = 8'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(($urandom_range(0, 49) != 0), r, 1'($urandom_range(0, 3) != 0));
    end

`ifdef MUXARB_STATS_EN
    applyStimulus(0, 8'h00, 1);
    for (int i = 0; i < 65538; i++) applyStimulus(1, 8'hFF, 1);
    checkOutput("cnt_wrap", {16'd0, xfer_cnt}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter: N, 8, data width in bits of each requester lane and of the output.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port: req  input  8  request vector; bit i belongs to requester i.
REQ-006 SHALL have ports: a0..a7  input  N each  data lane of requester 0..7.
REQ-007 SHALL have port: gnt  output  8  one-hot grant, combinational, high in the capture cycle only.
REQ-008 SHALL have port: sel  output  3  registered index of the requester whose data is in out_data.
REQ-009 SHALL have port: out_data  output  N  registered selected data.
REQ-010 SHALL have port: out_valid  output  1  out_data holds an untransferred word.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts out_data when high with out_valid.

Function
REQ-012 SHALL implement an FSM with two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 SHALL define accept = (state==IDLE) | (state==HOLD & out_ready).
REQ-014 SHALL, when accept=1 and req!=0, choose winner w = the first i with req[i]=1, scanning ptr, ptr+1, ... modulo 8.
REQ-015 SHALL, in that cycle, drive gnt = one-hot(w), else gnt = 0.
REQ-016 SHALL capture a_w into out_data and w into sel on that edge, and go to or stay in HOLD.
REQ-017 SHALL give a latency of 1 cycle: req sampled in IDLE produces out_valid on the next cycle.
REQ-018 SHALL update ptr to (w+1) mod 8 on each capture; w=7 wraps ptr to 0.
REQ-019 SHALL go from HOLD to IDLE when out_ready=1 and req=0.
REQ-020 SHALL keep state in HOLD, and keep out_data and sel stable, when out_ready=0.
REQ-021 SHALL assert gnt=0 while out_ready=0, even with req pending.
REQ-022 SHALL sustain one transfer per cycle while out_ready=1 and req!=0: an accept with a transfer and a new capture in the same cycle.
REQ-023 SHALL not be affected by requests that drop after capture; out_data is already latched.
REQ-024 SHALL, with a single requester asserted continuously, grant it on every accept.
REQ-025 SHALL give each persistently requesting requester a grant within 8 captures (starvation-free).

Reset
REQ-026 SHALL apply the following on a clk edge with rst_n=0: state=IDLE, ptr=0, sel=0, out_data=0, out_valid=0.
REQ-027 SHALL hold gnt=0 for the whole time rst_n=0.
REQ-028 SHALL discard a pending HOLD word when reset is asserted mid-operation; out_valid=0 on the next cycle.
REQ-029 SHALL treat the first request after reset with ptr=0, so the lowest-index requester wins.

Configuration
REQ-030 SHALL, with macro MUXARB_STATS_EN defined, add output port xfer_cnt (16 bits).
REQ-031 SHALL, with MUXARB_STATS_EN defined, increment xfer_cnt on every out_valid & out_ready, wrap 16'hFFFF to 0, and reset it to 0.
REQ-032 SHALL, without MUXARB_STATS_EN, have no xfer_cnt port and otherwise identical behaviour.

Verification
REQ-033 SHALL cover: reset, then req=8'b0000_0001, a0=8'hA5, out_ready=1 -> gnt=01 for 1 cycle; next cycle out_valid=1, out_data=A5, sel=0.
REQ-034 SHALL cover: req=8'hFF held, out_ready=1 -> sel sequence 0,1,2,...,7,0 on consecutive cycles, out_valid high continuously.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with req=8'hFF -> out_data/sel frozen, gnt=0; when out_ready rises -> transfer, and the next winner is sel+1.
REQ-036 SHALL cover: ptr=6 with req=8'b0100_0001 -> requester 6 wins; then requester 0 wins (wrap).
REQ-037 SHALL cover: rst_n=0 asserted while in HOLD -> out_valid=0, sel=0, out_data=0 next cycle; the first grant afterward goes to the lowest requesting index.
REQ-038 SHALL cover, with MUXARB_STATS_EN: 65537 transfers -> xfer_cnt=1; without the macro, the build has no xfer_cnt port.
